gridwalk_param: RTL and testbench



---
 rtl/gridwalk_pkg.sv | 14 +
 rtl/gridwalk_param_if.sv | 36 +++
 rtl/rotor_filter.sv | 77 +++++++
 rtl/gridwalk_param.sv | 137 +++++++++++++
 tb/tb_gridwalk_param.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gridwalk_pkg.sv
// Shared constants and helpers for the grid walker and its rotary-encoder front end.
package gridwalk_pkg;

    localparam logic DIR_INC  = 1'b1;
    localparam logic DIR_DEC  = 1'b0;
    localparam logic AXIS_COL = 1'b0;
    localparam logic AXIS_ROW = 1'b1;

    // Width of an index that must address n positions; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gridwalk_param_if.sv
// Encoder/switch inputs and cursor/marker outputs of the grid walker, bundled as one port.
interface gridwalk_param_if #(
    parameter int COLS = 8,
    parameter int ROWS = 8
);
    import gridwalk_pkg::*;

    localparam int CW = idx_w(COLS);
    localparam int RW = idx_w(ROWS);

    logic            rota;
    logic            rotb;
    logic            axis;
    logic            wrap_en;
    logic            home;
    logic [CW-1:0]   col_idx;
    logic [RW-1:0]   row_idx;
    logic [COLS-1:0] led;
    logic [ROWS-1:0] row_led;
    logic            step_valid;
    logic            step_dir;
    logic            at_edge;

    // Board side: drives the encoder and switches, reads the cursor.
    modport master (
        output rota, rotb, axis, wrap_en, home,
        input  col_idx, row_idx, led, row_led, step_valid, step_dir, at_edge
    );

    // Walker side.
    modport slave (
        input  rota, rotb, axis, wrap_en, home,
        output col_idx, row_idx, led, row_led, step_valid, step_dir, at_edge
    );

endinterface

// File: rtl/rotor_filter.sv
// Quadrature encoder front end: synchronise and debounce both phases, then turn each
// clean rising edge of phase A into a one-cycle event with the direction read from B.
module rotor_filter
    import gridwalk_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rota,
    input  logic rotb,
    output logic o_event,
    output logic o_dir
);

    localparam logic [7:0] CNT_MAX = 8'(DEB_CYCLES - 1);

    // Bit 0 carries phase A, bit 1 carries phase B.
    logic [1:0] w_raw;
    logic [1:0] r_s1;
    logic [1:0] r_s2;
    logic [1:0] r_flt;
    logic [7:0] r_cnt [2];
    logic       r_a_prev;
    logic [1:0] r_sync_ok;
    logic       r_arm;

    assign w_raw = {rotb, rota};

    // Two-flop synchroniser on both raw encoder lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // Per-line debounce: the filtered value follows only after DEB_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flt <= '0;
            for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] == r_flt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_flt[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Edge history plus an arm flag: after reset, A must be seen low before any rise counts,
    // so an encoder left high across reset does not produce a spurious step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_prev  <= 1'b0;
            r_sync_ok <= '0;
            r_arm     <= 1'b0;
        end else begin
            r_a_prev  <= r_flt[0];
            r_sync_ok <= {r_sync_ok[0], 1'b1};
            r_arm     <= r_arm | (r_sync_ok[1] & ~r_s2[0]);
        end
    end

    assign o_event = r_flt[0] & ~r_a_prev & r_arm;
    assign o_dir   = r_flt[1] ? DIR_DEC : DIR_INC;

endmodule

// File: rtl/gridwalk_param.sv
// Grid walker: moves a (column,row) cursor one cell per encoder detent along the chosen
// axis, wrapping or saturating at the edges, and drives one-hot column/row markers.
module gridwalk_param
    import gridwalk_pkg::*;
#(
    parameter int COLS       = 8,
    parameter int ROWS       = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    gridwalk_param_if.slave   bus
);

    localparam int CW = idx_w(COLS);
    localparam int RW = idx_w(ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    logic          w_event;
    logic          w_dir;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_step_valid;
    logic          r_at_edge;
    logic          r_step_dir;
    logic [CW-1:0] w_col_nxt;
    logic [RW-1:0] w_row_nxt;
    logic          w_step_valid_nxt;
    logic          w_at_edge_nxt;
    logic          w_step_dir_nxt;

    rotor_filter #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_rotor_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .rota    (bus.rota),
        .rotb    (bus.rotb),
        .o_event (w_event),
        .o_dir   (w_dir)
    );

    // Next cursor state: home wins over a same-cycle event, which is then dropped.
    always_comb begin
        w_col_nxt        = r_col;
        w_row_nxt        = r_row;
        w_step_valid_nxt = 1'b0;
        w_at_edge_nxt    = 1'b0;
        w_step_dir_nxt   = r_step_dir;
        if (bus.home) begin
            w_col_nxt = '0;
            w_row_nxt = '0;
        end else if (w_event) begin
            w_step_dir_nxt = w_dir;
            if (bus.axis == AXIS_COL) begin
                if (w_dir == DIR_INC) begin
                    if (r_col == COL_LAST) begin
                        if (bus.wrap_en) begin
                            w_col_nxt        = '0;
                            w_step_valid_nxt = 1'b1;
                        end else begin
                            w_at_edge_nxt    = 1'b1;
                        end
                    end else begin
                        w_col_nxt        = r_col + CW'(1);
                        w_step_valid_nxt = 1'b1;
                    end
                end else begin
                    if (r_col == '0) begin
                        if (bus.wrap_en) begin
                            w_col_nxt        = COL_LAST;
                            w_step_valid_nxt = 1'b1;
                        end else begin
                            w_at_edge_nxt    = 1'b1;
                        end
                    end else begin
                        w_col_nxt        = r_col - CW'(1);
                        w_step_valid_nxt = 1'b1;
                    end
                end
            end else begin
                if (w_dir == DIR_INC) begin
                    if (r_row == ROW_LAST) begin
                        if (bus.wrap_en) begin
                            w_row_nxt        = '0;
                            w_step_valid_nxt = 1'b1;
                        end else begin
                            w_at_edge_nxt    = 1'b1;
                        end
                    end else begin
                        w_row_nxt        = r_row + RW'(1);
                        w_step_valid_nxt = 1'b1;
                    end
                end else begin
                    if (r_row == '0) begin
                        if (bus.wrap_en) begin
                            w_row_nxt        = ROW_LAST;
                            w_step_valid_nxt = 1'b1;
                        end else begin
                            w_at_edge_nxt    = 1'b1;
                        end
                    end else begin
                        w_row_nxt        = r_row - RW'(1);
                        w_step_valid_nxt = 1'b1;
                    end
                end
            end
        end
    end

    // Cursor and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col        <= '0;
            r_row        <= '0;
            r_step_valid <= 1'b0;
            r_at_edge    <= 1'b0;
            r_step_dir   <= 1'b0;
        end else begin
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_step_valid <= w_step_valid_nxt;
            r_at_edge    <= w_at_edge_nxt;
            r_step_dir   <= w_step_dir_nxt;
        end
    end

    assign bus.col_idx    = r_col;
    assign bus.row_idx    = r_row;
    assign bus.led        = COLS'(1) << r_col;
    assign bus.row_led    = ROWS'(1) << r_row;
    assign bus.step_valid = r_step_valid;
    assign bus.at_edge    = r_at_edge;
    assign bus.step_dir   = r_step_dir;

endmodule

// File: tb/tb_gridwalk_param.sv
// Bench for gridwalk_param: detent stimulus (directed and random) feeds a cursor model
// whose predicted pulses are queued; a monitor pops and compares on every DUT pulse.
module tb_gridwalk_param;

    localparam int COLS = 8;
    localparam int ROWS = 8;
    localparam int DEB  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    gridwalk_param_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

    gridwalk_param #(.COLS(COLS), .ROWS(ROWS), .DEB_CYCLES(DEB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit sv;
        bit ae;
        bit dir;
        int col;
        int row;
        int t0;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   m_col;
    int   m_row;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cursor model: move along the axis, wrap modulo N or refuse the step at the edge.
    function automatic exp_t predict(input bit dir, input bit axis, input bit wrap, input int t0);
        exp_t e;
        int n   = axis ? ROWS : COLS;
        int pos = axis ? m_row : m_col;
        int tgt = dir ? pos + 1 : pos - 1;
        e.dir = dir;
        e.t0  = t0;
        e.sv  = 1'b0;
        e.ae  = 1'b0;
        if (tgt >= 0 && tgt < n) begin
            pos  = tgt;
            e.sv = 1'b1;
        end else if (wrap) begin
            pos  = (tgt + n) % n;
            e.sv = 1'b1;
        end else begin
            e.ae = 1'b1;
        end
        if (axis) m_row = pos;
        else      m_col = pos;
        e.col = m_col;
        e.row = m_row;
        return e;
    endfunction

    // Monitor: every step/edge pulse must match the oldest predicted event.
    always @(negedge clk) begin
        if (rst_n && (bus.step_valid || bus.at_edge)) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse step_valid=%0b at_edge=%0b col=%0d row=%0d required=no_pulse",
                         bus.step_valid, bus.at_edge, bus.col_idx, bus.row_idx);
            end else begin
                mon_e = q.pop_front();
                check("step_valid", int'(bus.step_valid), int'(mon_e.sv));
                check("at_edge",    int'(bus.at_edge),    int'(mon_e.ae));
                check("step_dir",   int'(bus.step_dir),   int'(mon_e.dir));
                check("col_idx",    int'(bus.col_idx),    mon_e.col);
                check("row_idx",    int'(bus.row_idx),    mon_e.row);
                check("led",        int'(bus.led),        1 << mon_e.col);
                check("row_led",    int'(bus.row_led),    1 << mon_e.row);
                check("latency",    cyc - mon_e.t0,       DEB + 3);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_col"},     int'(bus.col_idx), m_col);
        check({tag, "_row"},     int'(bus.row_idx), m_row);
        check({tag, "_led"},     int'(bus.led),     1 << m_col);
        check({tag, "_row_led"}, int'(bus.row_led), 1 << m_row);
    endtask

    // One detent: B set well ahead, A raised for hold cycles; optionally home hits the event cycle.
    task automatic detent(input bit dir, input bit home_hit, input int hold);
        bus.rotb = dir ? 1'b0 : 1'b1;
        idle(12);
        bus.rota = 1'b1;
        if (home_hit) begin
            m_col = 0;
            m_row = 0;
            idle(DEB + 2);
            bus.home = 1'b1;
            idle(1);
            bus.home = 1'b0;
            idle(hold - DEB - 3);
        end else begin
            q.push_back(predict(dir, bus.axis, bus.wrap_en, cyc));
            idle(hold);
        end
        bus.rota = 1'b0;
        idle(20);
    endtask

    task automatic do_home();
        bus.home = 1'b1;
        idle(1);
        bus.home = 1'b0;
        m_col = 0;
        m_row = 0;
        idle(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.rota    = 1'b0;
        bus.rotb    = 1'b0;
        bus.axis    = 1'b0;
        bus.wrap_en = 1'b1;
        bus.home    = 1'b0;
        m_col = 0;
        m_row = 0;

        // Reset state.
        idle(3);
        check("rst_col",        int'(bus.col_idx),    0);
        check("rst_row",        int'(bus.row_idx),    0);
        check("rst_led",        int'(bus.led),        1);
        check("rst_row_led",    int'(bus.row_led),    1);
        check("rst_step_valid", int'(bus.step_valid), 0);
        check("rst_at_edge",    int'(bus.at_edge),    0);
        check("rst_step_dir",   int'(bus.step_dir),   0);
        rst_n = 1'b1;
        idle(10);
        check_pos("post_rst");

        // Three +1 column steps.
        for (int i = 0; i < 3; i++) detent(1'b1, 1'b0, 20);
        check("t2_col", int'(bus.col_idx), 3);
        check("t2_led", int'(bus.led), 8'b0000_1000);
        check("t2_row", int'(bus.row_idx), 0);

        // -1 from column 0 with wrap, then with saturation.
        do_home();
        bus.wrap_en = 1'b1;
        detent(1'b0, 1'b0, 20);
        check("t3_wrap_col", int'(bus.col_idx), 7);
        check("t3_wrap_led", int'(bus.led), 8'b1000_0000);
        check("t3_wrap_dir", int'(bus.step_dir), 0);
        do_home();
        bus.wrap_en = 1'b0;
        detent(1'b0, 1'b0, 20);
        check("t3_sat_col", int'(bus.col_idx), 0);
        check("t3_sat_dir", int'(bus.step_dir), 0);

        // Short glitch on A is filtered out, then a real detent.
        bus.wrap_en = 1'b1;
        bus.rotb    = 1'b0;
        idle(12);
        bus.rota = 1'b1;
        idle(2);
        bus.rota = 1'b0;
        idle(20);
        check_pos("t4_glitch");
        detent(1'b1, 1'b0, 10);
        check("t4_col", int'(bus.col_idx), 1);

        // Row axis, then home colliding with an event.
        do_home();
        bus.axis = 1'b0;
        for (int i = 0; i < 2; i++) detent(1'b1, 1'b0, 20);
        bus.axis = 1'b1;
        for (int i = 0; i < 5; i++) detent(1'b1, 1'b0, 20);
        check("t5_row",     int'(bus.row_idx), 5);
        check("t5_row_led", int'(bus.row_led), 8'b0010_0000);
        check("t5_col",     int'(bus.col_idx), 2);
        detent(1'b1, 1'b1, 20);
        check_pos("t5_home");

        // Reset in the middle of debouncing a rise; A still high at release.
        bus.axis = 1'b0;
        bus.rotb = 1'b0;
        idle(12);
        bus.rota = 1'b1;
        idle(2);
        rst_n = 1'b0;
        m_col = 0;
        m_row = 0;
        idle(3);
        rst_n = 1'b1;
        idle(30);
        check_pos("t6_after_rst");
        bus.rota = 1'b0;
        idle(20);
        detent(1'b1, 1'b0, 20);
        check("t6_col", int'(bus.col_idx), 1);
        check("t6_row", int'(bus.row_idx), 0);

        // Randomised detents over axis, direction, edge mode and home collisions.
        for (int i = 0; i < 40; i++) begin
            bus.axis    = 1'($urandom_range(0, 1));
            bus.wrap_en = 1'($urandom_range(0, 1));
            detent(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 10 + int'($urandom_range(0, 10)));
        end
        check_pos("rand_end");

        idle(10);
        check("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
